// File: rtl/fused_arith_pkg.sv
// Shared widths, step counts, FSM states and result payload for the fused
// signed MAC/divider family.
package fused_arith_pkg;

  localparam int unsigned FULL_DVD_W = 16;
  localparam int unsigned FULL_DVS_W = 8;
  localparam int unsigned LANE_DVD_W = 12;
  localparam int unsigned LANE_DVS_W = 4;
  localparam int unsigned N_FULL     = 16;
  localparam int unsigned N_SPLIT    = 12;
  localparam int unsigned BUS_DVD_W  = 2 * LANE_DVD_W;
  localparam int unsigned BUS_DVS_W  = 2 * LANE_DVS_W;
  localparam int unsigned CNT_W      = $clog2(N_FULL);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  typedef struct packed {
    logic [BUS_DVD_W-1:0] quotient;
    logic [BUS_DVS_W-1:0] remainder;
    logic [1:0]           div_by_zero;
  } div_result_t;

endpackage

// File: rtl/signed_div_lane_step.sv
// One radix-2 restoring step on magnitudes. The quotient bit is shifted into
// the LSB of dvd_next as the dividend MSB is consumed.
module signed_div_lane_step #(
  parameter int unsigned DVD_W = 16,
  parameter int unsigned DVS_W = 8
) (
  input  logic [DVS_W-1:0] prem,
  input  logic [DVD_W-1:0] dvd,
  input  logic [DVS_W-1:0] dvs_mag,
  output logic [DVS_W-1:0] prem_next,
  output logic [DVD_W-1:0] dvd_next
);

  logic [DVS_W:0] shifted;
  logic [DVS_W:0] trial;
  logic           qbit;

  always_comb begin
    shifted   = {prem, dvd[DVD_W-1]};
    trial     = shifted - {1'b0, dvs_mag};
    qbit      = (shifted >= {1'b0, dvs_mag});
    prem_next = qbit ? DVS_W'(trial) : DVS_W'(shifted);
    dvd_next  = {dvd[DVD_W-2:0], qbit};
  end

endmodule

// File: rtl/fused_signed_div_16d8_2x12d4.sv
// Sequential signed divider: one 16b/8b division or two parallel 12b/4b lanes,
// restoring division on magnitudes with sign fix-up on the final step.
module fused_signed_div_16d8_2x12d4
  import fused_arith_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 split,
  input  logic [BUS_DVD_W-1:0] dividend,
  input  logic [BUS_DVS_W-1:0] divisor,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BUS_DVD_W-1:0] quotient,
  output logic [BUS_DVS_W-1:0] remainder,
  output logic [1:0]           div_by_zero
);

  state_t               state, state_next;
  logic [CNT_W-1:0]     cnt;
  logic                 split_q;
  logic [BUS_DVD_W-1:0] shreg, shreg_n, acc_shreg;
  logic [BUS_DVS_W-1:0] prem, prem_n;
  logic [BUS_DVS_W-1:0] dvs_mag, acc_dvs;
  logic [1:0]           sgn_dvd, sgn_dvs, acc_sd, acc_sv;
  div_result_t          res;

  logic [FULL_DVD_W-1:0] in_dvd_f, dvd_full_n, q_full;
  logic [FULL_DVS_W-1:0] in_dvs_f, prem_full_n, r_full;
  logic [LANE_DVD_W-1:0] in_dvd_lo, in_dvd_hi, dvd_lo_n, dvd_hi_n, q_lo, q_hi;
  logic [LANE_DVS_W-1:0] in_dvs_lo, in_dvs_hi, prem_lo_n, prem_hi_n, r_lo, r_hi;

  assign in_dvd_f  = dividend[FULL_DVD_W-1:0];
  assign in_dvs_f  = divisor;
  assign in_dvd_lo = dividend[LANE_DVD_W-1:0];
  assign in_dvd_hi = dividend[BUS_DVD_W-1:LANE_DVD_W];
  assign in_dvs_lo = divisor[LANE_DVS_W-1:0];
  assign in_dvs_hi = divisor[BUS_DVS_W-1:LANE_DVS_W];

  signed_div_lane_step #(.DVD_W(FULL_DVD_W), .DVS_W(FULL_DVS_W)) u_step_full (
    .prem(prem), .dvd(shreg[FULL_DVD_W-1:0]), .dvs_mag(dvs_mag),
    .prem_next(prem_full_n), .dvd_next(dvd_full_n)
  );
  signed_div_lane_step #(.DVD_W(LANE_DVD_W), .DVS_W(LANE_DVS_W)) u_step_lo (
    .prem(prem[LANE_DVS_W-1:0]), .dvd(shreg[LANE_DVD_W-1:0]),
    .dvs_mag(dvs_mag[LANE_DVS_W-1:0]), .prem_next(prem_lo_n), .dvd_next(dvd_lo_n)
  );
  signed_div_lane_step #(.DVD_W(LANE_DVD_W), .DVS_W(LANE_DVS_W)) u_step_hi (
    .prem(prem[BUS_DVS_W-1:LANE_DVS_W]), .dvd(shreg[BUS_DVD_W-1:LANE_DVD_W]),
    .dvs_mag(dvs_mag[BUS_DVS_W-1:LANE_DVS_W]), .prem_next(prem_hi_n), .dvd_next(dvd_hi_n)
  );

  // Operand capture: signs and magnitudes laid out per mode.
  always_comb begin
    acc_shreg = '0;
    acc_dvs   = '0;
    acc_sd    = '0;
    acc_sv    = '0;
    if (split) begin
      acc_sd    = {in_dvd_hi[LANE_DVD_W-1], in_dvd_lo[LANE_DVD_W-1]};
      acc_sv    = {in_dvs_hi[LANE_DVS_W-1], in_dvs_lo[LANE_DVS_W-1]};
      acc_shreg = {acc_sd[1] ? -in_dvd_hi : in_dvd_hi, acc_sd[0] ? -in_dvd_lo : in_dvd_lo};
      acc_dvs   = {acc_sv[1] ? -in_dvs_hi : in_dvs_hi, acc_sv[0] ? -in_dvs_lo : in_dvs_lo};
    end else begin
      acc_sd[0] = in_dvd_f[FULL_DVD_W-1];
      acc_sv[0] = in_dvs_f[FULL_DVS_W-1];
      acc_shreg = {(BUS_DVD_W-FULL_DVD_W)'(0), acc_sd[0] ? -in_dvd_f : in_dvd_f};
      acc_dvs   = acc_sv[0] ? -in_dvs_f : in_dvs_f;
    end
  end

  // Step result selection and sign fix-up; wrap on most-negative / -1 is natural.
  always_comb begin
    shreg_n = split_q ? {dvd_hi_n, dvd_lo_n}
                      : {(BUS_DVD_W-FULL_DVD_W)'(0), dvd_full_n};
    prem_n  = split_q ? {prem_hi_n, prem_lo_n} : prem_full_n;

    q_full = (sgn_dvd[0] ^ sgn_dvs[0]) ? -dvd_full_n : dvd_full_n;
    r_full = sgn_dvd[0] ? -prem_full_n : prem_full_n;
    q_lo   = (sgn_dvd[0] ^ sgn_dvs[0]) ? -dvd_lo_n : dvd_lo_n;
    r_lo   = sgn_dvd[0] ? -prem_lo_n : prem_lo_n;
    q_hi   = (sgn_dvd[1] ^ sgn_dvs[1]) ? -dvd_hi_n : dvd_hi_n;
    r_hi   = sgn_dvd[1] ? -prem_hi_n : prem_hi_n;

    res = '0;
    if (split_q) begin
      if (dvs_mag[LANE_DVS_W-1:0] == '0) begin
        q_lo = '1;
        r_lo = '0;
        res.div_by_zero[0] = 1'b1;
      end
      if (dvs_mag[BUS_DVS_W-1:LANE_DVS_W] == '0) begin
        q_hi = '1;
        r_hi = '0;
        res.div_by_zero[1] = 1'b1;
      end
      res.quotient  = {q_hi, q_lo};
      res.remainder = {r_hi, r_lo};
    end else begin
      if (dvs_mag == '0) begin
        q_full = '1;
        r_full = '0;
        res.div_by_zero[0] = 1'b1;
      end
      res.quotient  = {{(BUS_DVD_W-FULL_DVD_W){q_full[FULL_DVD_W-1]}}, q_full};
      res.remainder = r_full;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = CALC;
      CALC:    if (cnt == '0) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= '0;
      cnt         <= '0;
      split_q     <= 1'b0;
      shreg       <= '0;
      prem        <= '0;
      dvs_mag     <= '0;
      sgn_dvd     <= '0;
      sgn_dvs     <= '0;
    end else begin
      state     <= state_next;
      in_ready  <= (state_next == IDLE);
      out_valid <= (state_next == DONE);
      case (state)
        IDLE: if (in_valid) begin
          split_q <= split;
          shreg   <= acc_shreg;
          dvs_mag <= acc_dvs;
          sgn_dvd <= acc_sd;
          sgn_dvs <= acc_sv;
          prem    <= '0;
          cnt     <= split ? CNT_W'(N_SPLIT - 1) : CNT_W'(N_FULL - 1);
        end
        CALC: begin
          shreg <= shreg_n;
          prem  <= prem_n;
          cnt   <= cnt - CNT_W'(1);
          if (cnt == '0) begin
            quotient    <= res.quotient;
            remainder   <= res.remainder;
            div_by_zero <= res.div_by_zero;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fused_signed_div_16d8_2x12d4.sv
// Self-checking bench: directed scenarios plus randomized operations compared
// against an integer-arithmetic reference of the signed division rules.
module tb_fused_signed_div_16d8_2x12d4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        split = 1'b0;
  logic [23:0] dividend = '0;
  logic [7:0]  divisor = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [23:0] quotient;
  logic [7:0]  remainder;
  logic [1:0]  div_by_zero;

  int tests = 0;
  int fails = 0;

  fused_signed_div_16d8_2x12d4 dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .split(split),
    .dividend(dividend), .divisor(divisor), .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  // Truncating signed division; zero divisor gives q=-1, r=0, flag.
  function automatic void ref_div(input int a, input int b, output int qi, output int ri, output bit z);
    if (b == 0) begin qi = -1; ri = 0; z = 1'b1; end
    else begin qi = a / b; ri = a % b; z = 1'b0; end
  endfunction

  function automatic void model(input logic sp, input logic [23:0] dd, input logic [7:0] dv,
                                output logic [23:0] q, output logic [7:0] r, output logic [1:0] z);
    int qi, ri, qh, rh;
    bit zl, zh;
    logic [15:0] d16, q16;
    logic [11:0] dl, dh;
    logic [3:0]  vl, vh;
    if (!sp) begin
      d16 = dd[15:0];
      ref_div(int'($signed(d16)), int'($signed(dv)), qi, ri, zl);
      q16 = 16'(qi);
      q = {{8{q16[15]}}, q16};
      r = 8'(ri);
      z = {1'b0, zl};
    end else begin
      dl = dd[11:0]; dh = dd[23:12]; vl = dv[3:0]; vh = dv[7:4];
      ref_div(int'($signed(dl)), int'($signed(vl)), qi, ri, zl);
      ref_div(int'($signed(dh)), int'($signed(vh)), qh, rh, zh);
      q = {12'(qh), 12'(qi)};
      r = {4'(rh), 4'(ri)};
      z = {zh, zl};
    end
  endfunction

  task automatic wait_ready;
    int guard = 0;
    while (!in_ready && guard < 60) begin @(posedge clk); #1; guard++; end
    if (!in_ready) begin
      tests++; fails++;
      $display("FAIL in_ready_timeout: in_ready=%0b required 1", in_ready);
    end
  endtask

  // Issue one operation, return its outputs and accept-to-out_valid latency.
  task automatic do_op(input logic sp, input logic [23:0] dd, input logic [7:0] dv,
                       output logic [23:0] q, output logic [7:0] r, output logic [1:0] z, output int lat);
    wait_ready();
    split = sp; dividend = dd; divisor = dv; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    if (!out_valid) begin
      tests++; fails++;
      $display("FAIL out_valid_timeout: out_valid=%0b required 1", out_valid);
    end
    q = quotient; r = remainder; z = div_by_zero;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tests++; if (in_ready !== 1'b1)     begin fails++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
    tests++; if (out_valid !== 1'b0)    begin fails++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
    tests++; if (quotient !== 24'h0)    begin fails++; $display("FAIL reset_quotient: got %h want 000000", quotient); end
    tests++; if (remainder !== 8'h0)    begin fails++; $display("FAIL reset_remainder: got %h want 00", remainder); end
    tests++; if (div_by_zero !== 2'b00) begin fails++; $display("FAIL reset_dbz: got %b want 00", div_by_zero); end
  endtask

  task automatic test_directed;
    logic [23:0] q; logic [7:0] r; logic [1:0] z; int lat;
    do_op(1'b0, 24'h0003E8, 8'd7, q, r, z, lat);
    tests++; if (q !== 24'h00008E) begin fails++; $display("FAIL full_pos_q: got %h want 00008e", q); end
    tests++; if (r !== 8'h06)      begin fails++; $display("FAIL full_pos_r: got %h want 06", r); end
    tests++; if (lat !== 16)       begin fails++; $display("FAIL full_latency: got %0d want 16", lat); end
    do_op(1'b0, 24'hFFFC18, 8'd7, q, r, z, lat);
    tests++; if (q !== 24'hFFFF72) begin fails++; $display("FAIL full_neg_q: got %h want ffff72", q); end
    tests++; if (r !== 8'hFA)      begin fails++; $display("FAIL full_neg_r: got %h want fa", r); end
    tests++; if (z !== 2'b00)      begin fails++; $display("FAIL full_neg_dbz: got %b want 00", z); end
    do_op(1'b1, 24'h800064, 8'hFD, q, r, z, lat);
    tests++; if (q !== 24'h800FDF) begin fails++; $display("FAIL split_q: got %h want 800fdf", q); end
    tests++; if (r !== 8'h01)      begin fails++; $display("FAIL split_r: got %h want 01", r); end
    tests++; if (lat !== 12)       begin fails++; $display("FAIL split_latency: got %0d want 12", lat); end
  endtask

  task automatic test_div_by_zero;
    logic [23:0] q; logic [7:0] r; logic [1:0] z; int lat;
    do_op(1'b0, 24'h000005, 8'h00, q, r, z, lat);
    tests++; if (q !== 24'hFFFFFF) begin fails++; $display("FAIL dbz_full_q: got %h want ffffff", q); end
    tests++; if (r !== 8'h00)      begin fails++; $display("FAIL dbz_full_r: got %h want 00", r); end
    tests++; if (z !== 2'b01)      begin fails++; $display("FAIL dbz_full_flag: got %b want 01", z); end
    tests++; if (lat !== 16)       begin fails++; $display("FAIL dbz_full_latency: got %0d want 16", lat); end
    do_op(1'b1, 24'h007064, 8'h03, q, r, z, lat);
    tests++; if (q !== 24'hFFF021) begin fails++; $display("FAIL dbz_hi_q: got %h want fff021", q); end
    tests++; if (r !== 8'h01)      begin fails++; $display("FAIL dbz_hi_r: got %h want 01", r); end
    tests++; if (z !== 2'b10)      begin fails++; $display("FAIL dbz_hi_flag: got %b want 10", z); end
  endtask

  task automatic test_backpressure;
    logic [23:0] eq; logic [7:0] er; logic [1:0] ez; int guard;
    model(1'b0, 24'h001234, 8'hF9, eq, er, ez);
    wait_ready();
    split = 1'b0; dividend = 24'h001234; divisor = 8'hF9; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    guard = 0;
    while (!out_valid && guard < 50) begin @(posedge clk); #1; guard++; end
    tests++; if (quotient !== eq) begin fails++; $display("FAIL bp_q: got %h want %h", quotient, eq); end
    tests++; if (remainder !== er) begin fails++; $display("FAIL bp_r: got %h want %h", remainder, er); end
    in_valid = 1'b1; dividend = 24'h000FFF; divisor = 8'h01;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL bp_hold_valid[%0d]: got %0b want 1", i, out_valid); end
      tests++; if (in_ready !== 1'b0)  begin fails++; $display("FAIL bp_in_ready[%0d]: got %0b want 0", i, in_ready); end
      tests++; if (quotient !== eq)    begin fails++; $display("FAIL bp_stable_q[%0d]: got %h want %h", i, quotient, eq); end
      tests++; if (remainder !== er)   begin fails++; $display("FAIL bp_stable_r[%0d]: got %h want %h", i, remainder, er); end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    tests++; if (in_ready !== 1'b1)  begin fails++; $display("FAIL bp_release_ready: got %0b want 1", in_ready); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_release_valid: got %0b want 0", out_valid); end
    repeat (3) @(posedge clk);
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_not_queued: in_ready=%0b want 1", in_ready); end
  endtask

  task automatic test_reset_mid_calc;
    logic [23:0] q; logic [7:0] r; logic [1:0] z; int lat;
    wait_ready();
    split = 1'b0; dividend = 24'h0003E8; divisor = 8'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    tests++; if (out_valid !== 1'b0)    begin fails++; $display("FAIL rstmid_valid: got %0b want 0", out_valid); end
    tests++; if (in_ready !== 1'b1)     begin fails++; $display("FAIL rstmid_ready: got %0b want 1", in_ready); end
    tests++; if (quotient !== 24'h0)    begin fails++; $display("FAIL rstmid_q: got %h want 000000", quotient); end
    tests++; if (remainder !== 8'h0)    begin fails++; $display("FAIL rstmid_r: got %h want 00", remainder); end
    tests++; if (div_by_zero !== 2'b00) begin fails++; $display("FAIL rstmid_dbz: got %b want 00", div_by_zero); end
    repeat (20) @(posedge clk);
    #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rstmid_discard: out_valid=%0b want 0", out_valid); end
    do_op(1'b0, 24'h0003E8, 8'd7, q, r, z, lat);
    tests++; if (q !== 24'h00008E) begin fails++; $display("FAIL rstmid_after_q: got %h want 00008e", q); end
    tests++; if (r !== 8'h06)      begin fails++; $display("FAIL rstmid_after_r: got %h want 06", r); end
  endtask

  task automatic test_random;
    logic sp; logic [23:0] dd; logic [7:0] dv;
    logic [23:0] q, eq; logic [7:0] r, er; logic [1:0] z, ez; int lat;
    for (int i = 0; i < 150; i++) begin
      sp = 1'($urandom_range(0, 1));
      dd = 24'($urandom);
      dv = 8'($urandom);
      if (!sp) begin
        case ($urandom_range(0, 7))
          0: dv = 8'h00;
          1: dv = 8'hFF;
          2: dd[15:0] = 16'h8000;
          3: begin dd[15:0] = 16'h8000; dv = 8'hFF; end
          4: dv = 8'h80;
          default: ;
        endcase
      end else begin
        case ($urandom_range(0, 7))
          0: dv[3:0] = 4'h0;
          1: dv[7:4] = 4'hF;
          2: begin dd[23:12] = 12'h800; dv[7:4] = 4'hF; end
          3: begin dd[11:0] = 12'h800; dv[3:0] = 4'h8; end
          4: dv = 8'h00;
          default: ;
        endcase
      end
      model(sp, dd, dv, eq, er, ez);
      do_op(sp, dd, dv, q, r, z, lat);
      tests++; if (q !== eq) begin fails++; $display("FAIL rand_q[%0d] sp=%0b dd=%h dv=%h: got %h want %h", i, sp, dd, dv, q, eq); end
      tests++; if (r !== er) begin fails++; $display("FAIL rand_r[%0d] sp=%0b dd=%h dv=%h: got %h want %h", i, sp, dd, dv, r, er); end
      tests++; if (z !== ez) begin fails++; $display("FAIL rand_dbz[%0d] sp=%0b dd=%h dv=%h: got %b want %b", i, sp, dd, dv, z, ez); end
      tests++; if (lat !== (sp ? 12 : 16)) begin fails++; $display("FAIL rand_lat[%0d]: got %0d want %0d", i, lat, sp ? 12 : 16); end
    end
  endtask

  // Consumer always ready, producer always valid: one op per N+2 cycles.
  task automatic test_back_to_back;
    logic sp; logic [23:0] dd; logic [7:0] dv;
    logic [23:0] eq; logic [7:0] er; logic [1:0] ez; int cyc; bit seen;
    wait_ready();
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      sp = 1'(k % 2);
      dd = 24'($urandom);
      dv = 8'($urandom);
      model(sp, dd, dv, eq, er, ez);
      split = sp; dividend = dd; divisor = dv; in_valid = 1'b1;
      cyc = 0; seen = 1'b0;
      do begin
        @(posedge clk); #1; cyc++;
        if (out_valid) begin
          seen = 1'b1;
          tests++; if (quotient !== eq) begin fails++; $display("FAIL b2b_q[%0d]: got %h want %h", k, quotient, eq); end
          tests++; if (remainder !== er) begin fails++; $display("FAIL b2b_r[%0d]: got %h want %h", k, remainder, er); end
        end
      end while (!(seen && in_ready) && cyc < 60);
      tests++; if (cyc !== (sp ? 14 : 18)) begin fails++; $display("FAIL b2b_period[%0d]: got %0d want %0d", k, cyc, sp ? 14 : 18); end
    end
    in_valid = 1'b0; out_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_div_by_zero();
    test_backpressure();
    test_reset_mid_calc();
    test_random();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
